// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: byte-serial instruction fetch sequencer.
// Assembles a big-endian 32-bit word from four single-byte reads, offers it to the
// core with a valid/ready handshake, handles redirects and flags misaligned or
// out-of-range fetches with a sticky fault.
// Optional build macro IFETCH_PREFETCH_EN adds a one-word prefetch buffer so the
// next word is fetched while the current one waits on out_ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

`ifdef IFETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  // Highest word address whose last byte still lies inside memory. Comparing the
  // word address itself (not pc+3) also rejects PCs that would wrap past 2^32.
  localparam logic [31:0] LAST_OK = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        pf_full_q, pf_full_d;
  logic [31:0] pf_instr_q, pf_instr_d;

  logic [31:0] asm_ins;
  logic [31:0] pc_next;

  function automatic logic in_range(input logic [31:0] a);
    return a <= LAST_OK;
  endfunction

  assign pc_next = pc_q + 32'd4;

  // Assembly register with the current byte dropped into lane 3-cnt (big-endian).
  always_comb begin
    asm_ins = asm_q;
    case (cnt_q)
      2'd0:    asm_ins[31:24] = mem_rdata;
      2'd1:    asm_ins[23:16] = mem_rdata;
      2'd2:    asm_ins[15:8]  = mem_rdata;
      default: asm_ins[7:0]   = mem_rdata;
    endcase
  end

  // Next-state, memory strobe and output update; redirect overrides everything last.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    fault_d     = fault_q;
    fault_pc_d  = fault_pc_q;
    pf_full_d   = pf_full_q;
    pf_instr_d  = pf_instr_q;
    mem_en      = 1'b0;
    mem_addr    = pc_q + {30'd0, cnt_q};

    case (state_q)
      S_FETCH: begin
        if (cnt_q == 2'd0 && !in_range(pc_q)) begin
          state_d    = S_FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end else begin
          mem_en = 1'b1;
          asm_d  = asm_ins;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            out_instr_d = asm_ins;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Here the fetch pointer runs ahead of pc by one word.
        mem_addr = pc_next + {30'd0, cnt_q};
        if (pf_full_q) begin
          // Buffered word replaces the output on transfer; no read this cycle.
          if (out_ready) begin
            out_instr_d = pf_instr_q;
            out_pc_d    = pc_next;
            pc_d        = pc_next;
            pf_full_d   = 1'b0;
          end
        end else if (!in_range(pc_next)) begin
          // Fault for the next word only surfaces once the current one drains.
          if (out_ready) begin
            pc_d        = pc_next;
            out_valid_d = 1'b0;
            state_d     = S_FAULT;
            fault_d     = 1'b1;
            fault_pc_d  = pc_next;
          end
        end else if (out_ready || PREFETCH) begin
          mem_en = 1'b1;
          asm_d  = asm_ins;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (out_ready) begin
              out_instr_d = asm_ins;
              out_pc_d    = pc_next;
              pc_d        = pc_next;
            end else begin
              pf_full_d  = 1'b1;
              pf_instr_d = asm_ins;
            end
          end else if (out_ready) begin
            pc_d        = pc_next;
            out_valid_d = 1'b0;
            state_d     = S_FETCH;
          end
        end
      end

      default: begin
        out_valid_d = 1'b0;
      end
    endcase

    if (redirect_valid) begin
      pc_d        = redirect_pc;
      cnt_d       = 2'd0;
      asm_d       = 32'd0;
      out_valid_d = 1'b0;
      pf_full_d   = 1'b0;
      fault_d     = 1'b0;
      if (redirect_pc[1:0] != 2'b00 || !in_range(redirect_pc)) begin
        state_d    = S_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      cnt_q       <= 2'd0;
      asm_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 32'd0;
      fault_q     <= 1'b0;
      fault_pc_q  <= 32'd0;
      pf_full_q   <= 1'b0;
      pf_instr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      fault_q     <= fault_d;
      fault_pc_q  <= fault_pc_d;
      pf_full_q   <= pf_full_d;
      pf_instr_q  <= pf_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences the byte-wide, asynchronous-read instruction memory. The block holds the PC and assembles one 32-bit big-endian instruction from four consecutive byte reads. It presents the instruction to the core with a valid/ready handshake, accepts branch/jump redirects, and flags misaligned or out-of-range fetches. It sits between the PC/next-PC logic and instruction memory, allowing the memory to be single-byte ported.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_BYTES, 100, instruction memory depth in bytes; valid fetch requires pc+3 <= MEM_BYTES-1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  output  32  byte address to instruction memory (combinational from state)
mem_en  output  1  high when mem_rdata is sampled this cycle
mem_rdata  input  8  byte read data, valid same cycle as mem_addr
out_valid  output  1  out_instr/out_pc hold a complete instruction
out_ready  input  1  core accepts instruction on rising edge when out_valid=1
out_instr  output  32  assembled instruction, byte at pc in [31:24]
out_pc  output  32  address of out_instr
redirect_valid  input  1  load redirect_pc, flush in-flight fetch
redirect_pc  input  32  redirect target
fault  output  1  sticky fetch fault
fault_pc  output  32  PC that caused fault

Behaviour:
- Reset (async, any state): pc=RESET_PC, byte counter cnt=0, state=FETCH, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, assembly register=0.
- States: FETCH (cnt 0..3), HOLD, FAULT.
- FETCH: mem_addr=pc+cnt, mem_en=1. Each edge latches mem_rdata into byte lane 3-cnt and increments cnt. The edge with cnt=3 sets out_instr, out_pc=pc, out_valid=1, and moves to HOLD.
- Latency: the first instruction is valid after the 4th edge following reset release.
- Range check on entering FETCH with cnt=0: if pc+3 > MEM_BYTES-1, go to FAULT instead, with fault=1 and fault_pc=pc. No memory read is issued in this case (mem_en=0).
- HOLD: mem_addr=pc+4.
  - out_ready=0: hold all outputs stable, mem_en=0.
  - out_ready=1: transfer occurs; pc+=4.
    - If pc+4 is in range: mem_en=1, byte0 of the next word is latched this edge, cnt=1, state FETCH, out_valid=0.
    - If pc+4 is out of range: go to FAULT as above with fault_pc=pc+4.
  - Sustained throughput: 1 instruction per 4 cycles with out_ready held high.
- FAULT: out_valid=0, mem_en=0, fault and fault_pc held. Exited only by redirect or reset.
- Redirect (any state) has priority over fetch progress.
  - At the edge: pc=redirect_pc, cnt=0, out_valid=0, partial assembly discarded, fault cleared.
  - If redirect_pc[1:0]!=0: FAULT with fault_pc=redirect_pc. Otherwise the range check applies, then FETCH.
- Redirect with out_valid=1 and out_ready=1 on the same edge: the transfer counts as completed (consumer keeps the word), then the redirect applies.
- PC arithmetic is 32-bit modulo. Wrap past 2^32 is caught by the range check because MEM_BYTES < 2^32.
- All outputs are registered except mem_addr and mem_en (combinational from state/pc/cnt/out_ready).

Optional Feature:
IFETCH_PREFETCH_EN
- Defined: adds a one-word prefetch buffer.
  - In HOLD with out_ready=0, fetching of pc+4 continues into the buffer.
  - When the buffer is full and the output is held, mem_en=0 (stall).
  - On transfer with a full buffer, the buffer moves to out in the same edge, so out_valid stays 1 and back-to-back issue is possible.
  - Redirect flushes the buffer.
  - A range fault detected during prefetch is deferred until the output drains; it is then reported as above.
- Undefined: no buffer; behaviour exactly as in Behaviour.

Test Plan:
- Mem[0..3]=20 08 00 05, out_ready=1, release reset -> mem_addr 0,1,2,3 on successive cycles; after 4th edge out_valid=1, out_instr=32'h20080005, out_pc=0; next word issues 4 cycles later at out_pc=4.
- out_ready=0 for 10 cycles after first word -> out_valid, out_instr, out_pc stable; mem_en=0; the out_ready pulse gives a transfer, then mem_addr=4, 5, 6, 7.
- Redirect_pc=0x40 asserted at cnt=2 -> partial word discarded; next edges read 0x40..0x43; out_pc=0x40; no stale word appears on out.
- MEM_BYTES=100, redirect to 96, out_ready=1 -> word at 96 delivered; then fault=1, fault_pc=100, out_valid=0, mem_en=0; redirect to 0 clears fault.
- Redirect_pc=0x06 -> fault=1, fault_pc=6, no memory reads; assert reset mid-fetch at cnt=2 -> all outputs immediately at reset values, fetch restarts at RESET_PC.
- With IFETCH_PREFETCH_EN defined: hold out_ready=0 for 8 cycles, then hold it high -> out_pc 0 and 4 on consecutive edges; without the macro, a 4-cycle gap between them.
